// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared definitions for the gate sweep controller: FSM state encoding,
// counter widths, the combination-index to {b,a} operand mapping and a
// saturating increment helper for the 8-bit counters.
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

  // Width of the error, pass and settle counters.
  localparam int CNT_W = 8;
  // Width of the combination index (four {b,a} combinations).
  localparam int IDX_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic b;
    logic a;
  } operand_t;

  // Index 0..3 maps to {b,a} = 00, 01, 10, 11.
  function automatic operand_t combo_operands(input logic [IDX_W-1:0] idx);
    operand_t op;
    op.b = idx[1];
    op.a = idx[0];
    return op;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// -----------------------------------------------------------------------------
// gate_sweep_ref
// Combinational expected-value function for the one_bit gate block.
// Ports:
//   a, b      : operands currently driven to the gate block
//   expected  : {c,d,e,f} = {a&b, a|b, a^b, ~(a&b)}
// -----------------------------------------------------------------------------
module gate_sweep_ref (
  input  logic       a,
  input  logic       b,
  output logic [3:0] expected
);

  assign expected = {a & b, a | b, a ^ b, ~(a & b)};

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Exhaustively exercises a one_bit gate block: drives all four {b,a}
// combinations, waits SETTLE_CYC cycles for each, compares the block's
// outputs against the expected gate functions and accumulates errors.
// The whole 4-combination sweep is repeated PASSES times per start.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle sweep request, honoured only when idle
//   abort             : ends a running sweep early (result marked failed)
//   a, b              : operand drives to the gate block
//   c, d, e, f        : gate block results (and, or, xor, nand)
//   busy              : high whenever a sweep is in progress
//   done              : one-cycle pulse when a sweep ends
//   pass_ok           : sweep verdict, valid with done and held afterwards
//   err_cnt           : failing combination checks, saturating at 255
//   fail_mask         : sticky failure flag per combination index
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int PASSES     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass_ok,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_PASS   = CNT_W'(PASSES - 1);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] settle_cnt;

  logic [3:0]       expected;
  logic [3:0]       observed;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;

  gate_sweep_ref u_ref (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Any number of wrong outputs for one combination is a single error.
  assign observed = {c, d, e, f};
  assign mismatch = (observed != expected);
  assign err_next = mismatch ? sat_inc(err_cnt) : err_cnt;

  // NOTE: every register is written with <= so all of them update together
  // from the values present before the edge; mixing in = here would let
  // later statements see half-updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_ok    <= 1'b0;
      err_cnt    <= '0;
      fail_mask  <= '0;
    end else begin
      // done is a pulse: low unless this cycle's transition enters DONE.
      done <= 1'b0;

      if (state != ST_IDLE && state != ST_DONE && abort) begin
        // Abort wins over every other transition and skips the compare.
        state   <= ST_DONE;
        done    <= 1'b1;
        pass_ok <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // start together with abort is treated as no request.
            if (start && !abort) begin
              state     <= ST_DRIVE;
              busy      <= 1'b1;
              idx       <= '0;
              pass_cnt  <= '0;
              err_cnt   <= '0;
              fail_mask <= '0;
              pass_ok   <= 1'b0;
            end
          end

          ST_DRIVE: begin
            {b, a}     <= combo_operands(idx);
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end

          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              state <= ST_CHECK;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end

          ST_CHECK: begin
            if (mismatch) begin
              err_cnt        <= err_next;
              fail_mask[idx] <= 1'b1;
            end
            if (idx != LAST_IDX) begin
              idx   <= idx + 1'b1;
              state <= ST_DRIVE;
            end else if (pass_cnt != LAST_PASS) begin
              idx      <= '0;
              pass_cnt <= pass_cnt + 1'b1;
              state    <= ST_DRIVE;
            end else begin
              // Verdict uses err_next so the final check is included.
              state   <= ST_DONE;
              done    <= 1'b1;
              pass_ok <= (err_next == '0);
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
// Two controllers (PASSES=1 and PASSES=3, SETTLE_CYC=4) each drive a bench
// model of the one_bit gate block with configurable stuck-at faults.
// The driver pushes the expected sweep result into a per-instance queue;
// a monitor pops and compares whenever done is seen.
// Cycle numbering: the cycle in which start is high is cycle s; the done
// pulse of an uninterrupted sweep is in cycle s + PASSES*4*(SETTLE_CYC+2) + 1,
// i.e. 26 cycles counting both the start and the done cycle.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

  localparam int SETTLE = 4;
  localparam int P0     = 1;
  localparam int P1     = 3;
  localparam int PER    = SETTLE + 2;

  typedef struct {
    logic       pass_ok;
    logic [7:0] err_cnt;
    logic [3:0] fail_mask;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, abort;
  logic [1:0] a, b, c, d, e, f;
  logic [1:0] busy, done, pass_ok;
  logic [7:0] err_cnt [2];
  logic [3:0] fail_mask [2];
  logic [3:0] stk0 [2];
  logic [3:0] stk1 [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t exp_q [2][$];
  exp_t held  [2];
  bit   post  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench model of the one_bit gate block, bits {c,d,e,f}, with stuck-at-0
  // and stuck-at-1 masks.
  function automatic logic [3:0] gate_out(input logic ga, input logic gb,
                                          input logic [3:0] s0, input logic [3:0] s1);
    logic [3:0] t;
    t = {ga & gb, ga | gb, ga ^ gb, ~(ga & gb)};
    return (t & ~s0) | s1;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_gate
    assign {c[gi], d[gi], e[gi], f[gi]} = gate_out(a[gi], b[gi], stk0[gi], stk1[gi]);
  end

  gate_sweep_ctrl #(.SETTLE_CYC(SETTLE), .PASSES(P0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]), .f(f[0]),
    .busy(busy[0]), .done(done[0]), .pass_ok(pass_ok[0]),
    .err_cnt(err_cnt[0]), .fail_mask(fail_mask[0])
  );

  gate_sweep_ctrl #(.SETTLE_CYC(SETTLE), .PASSES(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .e(e[1]), .f(f[1]),
    .busy(busy[1]), .done(done[1]), .pass_ok(pass_ok[1]),
    .err_cnt(err_cnt[1]), .fail_mask(fail_mask[1])
  );

  task automatic check(input string name, input int inst, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s inst%0d @cycle %0d: got %0d, want %0d", name, inst, cyc, act, want);
    end
  endtask

  // Reference: walk the sweep's checks in order; check j happens in cycle
  // s + (j+1)*PER and is skipped if abort was sampled in or before that cycle.
  function automatic exp_t model(input int passes, input int s, input int abort_cyc,
                                 input logic [3:0] s0, input logic [3:0] s1);
    exp_t       r;
    logic [1:0] k;
    r.err_cnt   = 0;
    r.fail_mask = 0;
    for (int j = 0; j < passes * 4; j++) begin
      if (abort_cyc >= 0 && s + (j + 1) * PER >= abort_cyc) break;
      k = 2'(j % 4);
      if (gate_out(k[0], k[1], s0, s1) != gate_out(k[0], k[1], 4'b0, 4'b0)) begin
        if (r.err_cnt != 8'd255) r.err_cnt = r.err_cnt + 8'd1;
        r.fail_mask[k] = 1'b1;
      end
    end
    if (abort_cyc >= 0) begin
      r.done_cyc = abort_cyc + 1;
      r.pass_ok  = 1'b0;
    end else begin
      r.done_cyc = s + passes * 4 * PER + 1;
      r.pass_ok  = (r.err_cnt == 0);
    end
    return r;
  endfunction

  // Monitor: compares each done pulse with the oldest expectation, then
  // checks the following cycle for idle and held results.
  always @(negedge clk) begin
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      if (post[i]) begin
        check("busy_after_done", i, busy[i], 0);
        check("done_one_cycle", i, done[i], 0);
        check("err_cnt_held", i, err_cnt[i], held[i].err_cnt);
        check("fail_mask_held", i, fail_mask[i], held[i].fail_mask);
        check("pass_ok_held", i, pass_ok[i], held[i].pass_ok);
        post[i] = 1'b0;
      end
      if (rst_n && done[i]) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done inst%0d @cycle %0d: got done=1, want no pulse", i, cyc);
        end else begin
          x = exp_q[i].pop_front();
          check("done_cycle", i, cyc, x.done_cyc);
          check("pass_ok", i, pass_ok[i], x.pass_ok);
          check("err_cnt", i, err_cnt[i], x.err_cnt);
          check("fail_mask", i, fail_mask[i], x.fail_mask);
          held[i] = x;
          post[i] = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_values(input int i);
    check("rst_a", i, a[i], 0);
    check("rst_b", i, b[i], 0);
    check("rst_busy", i, busy[i], 0);
    check("rst_done", i, done[i], 0);
    check("rst_pass_ok", i, pass_ok[i], 0);
    check("rst_err_cnt", i, err_cnt[i], 0);
    check("rst_fail_mask", i, fail_mask[i], 0);
  endtask

  // One sweep on instance i. abort_off < 0 means no abort, otherwise abort
  // is high in cycle s + abort_off. repulse re-issues start mid-sweep and
  // in the done cycle.
  task automatic run_sweep(input int i, input logic [3:0] s0, input logic [3:0] s1,
                           input int abort_off, input bit repulse, input bit release_rst);
    int s, t, last, passes;
    bit ended;
    passes = (i == 0) ? P0 : P1;
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    stk0[i]  = s0;
    stk1[i]  = s1;
    start[i] = 1'b1;
    s        = cyc;
    t        = (abort_off < 0) ? -1 : s + abort_off;
    last     = s + passes * 4 * PER + 1;
    exp_q[i].push_back(model(passes, s, t, s0, s1));
    ended = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cyc >= s + 2 && !busy[i]) begin
        ended = 1'b1;
        break;
      end
      abort[i] = (cyc == t);
      start[i] = repulse && (cyc == s + 3 || cyc == last);
    end
    start[i] = 1'b0;
    abort[i] = 1'b0;
    check("sweep_ends", i, ended, 1);
  endtask

  initial begin
    int         s, inst, aoff;
    logic [3:0] r0, r1;
    bit         ended;

    rst_n = 1'b0;
    start = '0;
    abort = '0;
    stk0[0] = '0; stk0[1] = '0;
    stk1[0] = '0; stk1[1] = '0;
    post[0] = 1'b0; post[1] = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);

    // Clean gate block, start on the first edge out of reset, start
    // re-pulsed while busy and in the done cycle.
    run_sweep(0, 4'b0000, 4'b0000, -1, 1'b1, 1'b1);
    // e stuck at 0: combinations 01 and 10 fail.
    run_sweep(0, 4'b0010, 4'b0000, -1, 1'b0, 1'b0);
    // Three passes with c stuck at 1: three failing combinations per pass.
    run_sweep(1, 4'b0000, 4'b1000, -1, 1'b1, 1'b0);
    // Abort in SETTLE of the second combination: only the first check counts.
    run_sweep(0, 4'b0000, 4'b1000, 10, 1'b0, 1'b0);
    // Abort exactly in a CHECK cycle: that compare is suppressed.
    run_sweep(0, 4'b0000, 4'b1000, 12, 1'b0, 1'b0);
    // Abort in the first DRIVE cycle of a multi-pass sweep.
    run_sweep(1, 4'b0000, 4'b1000, 1, 1'b0, 1'b0);

    // start and abort together in IDLE, and abort alone, do nothing.
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    abort[1] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort    = '0;
    check("idle_start_abort_busy", 0, busy[0], 0);
    check("idle_abort_busy", 1, busy[1], 0);
    @(negedge clk);
    check("idle_start_abort_busy2", 0, busy[0], 0);

    // Asynchronous reset in the middle of SETTLE.
    @(negedge clk);
    stk0[0]  = 4'b0000;
    stk1[0]  = 4'b1000;
    start[0] = 1'b1;
    s        = cyc;
    exp_q[0].push_back(model(P0, s, -1, 4'b0000, 4'b1000));
    @(negedge clk);
    start[0] = 1'b0;
    ended = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cyc >= s + 3) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_settle", 0, ended, 1);
    check("busy_before_reset", 0, busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    check("reset_no_done", 0, done[0], 0);
    run_sweep(0, 4'b0000, 4'b0000, -1, 1'b0, 1'b1);

    // Randomised sweeps, faults and aborts.
    for (int n = 0; n < 24; n++) begin
      inst = int'($urandom_range(0, 1));
      r0   = 4'($urandom_range(0, 15));
      r1   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        r0 = '0;
        r1 = '0;
      end
      if ($urandom_range(0, 1) == 0) aoff = -1;
      else aoff = int'($urandom_range(1, ((inst == 0) ? P0 : P1) * 4 * PER));
      run_sweep(inst, r0, r1, aoff, aoff < 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 0, exp_q[0].size(), 0);
    check("queue_empty", 1, exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog @cycle %0d: got no finish, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
